// File: rtl/prescaled_tick_timer_if.sv
// prescaled_tick_timer_if
//   Bundles the control and status signals of prescaled_tick_timer so the
//   timer and its controller can be connected through one port.
//
//   master modport (controller side):
//     drives  start, stop, oneshot, prescale[PRESCALE_W], period[CNT_W]
//     reads   count[CNT_W], tick, toggle_out, busy, done
//   slave modport (timer side): the same signals with directions reversed.
//
//   Clock and reset are not part of the bundle; they stay plain ports on the
//   timer.
interface prescaled_tick_timer_if #(
  parameter int PRESCALE_W = 8,
  parameter int CNT_W      = 16
);
  logic                  start;
  logic                  stop;
  logic                  oneshot;
  logic [PRESCALE_W-1:0] prescale;
  logic [CNT_W-1:0]      period;
  logic [CNT_W-1:0]      count;
  logic                  tick;
  logic                  toggle_out;
  logic                  busy;
  logic                  done;

  modport master (
    output start, stop, oneshot, prescale, period,
    input  count, tick, toggle_out, busy, done
  );

  modport slave (
    input  start, stop, oneshot, prescale, period,
    output count, tick, toggle_out, busy, done
  );
endinterface

// File: rtl/prescaled_tick_timer.sv
// prescaled_tick_timer
//   Programmable periodic / one-shot timer. A prescaler produces an enable
//   every P+1 clocks. A period counter advances on each enable and wraps
//   after N+1 enables. Each wrap raises tick for one cycle and flips
//   toggle_out, so the tick spacing is (P+1)*(N+1) clocks. In one-shot mode
//   the first wrap also ends the run and sets the sticky done flag.
//
//   Ports:
//     clk    - system clock; all logic changes on the rising edge
//     rst_n  - synchronous reset, active low; it takes priority over start
//              and stop
//     bus    - prescaled_tick_timer_if.slave, which carries:
//                start/stop  one-cycle requests
//                oneshot     mode; latched when start is accepted
//                prescale    P; latched when start is accepted
//                period      N; latched when start is accepted
//                count       current period counter value
//                tick        one-cycle pulse at terminal count
//                toggle_out  flips on every tick
//                busy        high while running
//                done        sticky; set when a one-shot completes
module prescaled_tick_timer #(
  parameter int PRESCALE_W = 8,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  prescaled_tick_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_reg;
  logic [PRESCALE_W-1:0] presc_reg;
  logic [PRESCALE_W-1:0] p_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      n_reg;
  logic                  oneshot_reg;
  logic                  tick_reg;
  logic                  toggle_reg;
  logic                  busy_reg;
  logic                  done_reg;

  // The enable fires when the prescaler reaches the latched divider value.
  // Both counters wrap on an equality compare, so they can never overflow.
  logic enable;
  logic terminal;
  assign enable   = (presc_reg == p_reg);
  assign terminal = enable && (count_reg == n_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      presc_reg   <= '0;
      p_reg       <= '0;
      count_reg   <= '0;
      n_reg       <= '0;
      oneshot_reg <= 1'b0;
      tick_reg    <= 1'b0;
      toggle_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      // tick is a single-cycle pulse. It is set only in the terminal branch
      // below.
      tick_reg <= 1'b0;

      if (bus.start && bus.stop) begin
        // When start and stop arrive together, stop wins. The configuration
        // is not relatched and the counters keep their current values.
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end else if (bus.stop && (state_reg == RUN)) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end else if (bus.start) begin
        // A start is accepted from any state, including a restart while
        // already running. toggle_out keeps its phase.
        state_reg   <= RUN;
        p_reg       <= bus.prescale;
        n_reg       <= bus.period;
        oneshot_reg <= bus.oneshot;
        presc_reg   <= '0;
        count_reg   <= '0;
        done_reg    <= 1'b0;
        busy_reg    <= 1'b1;
      end else if (state_reg == RUN) begin
        if (enable) begin
          presc_reg <= '0;
        end else begin
          presc_reg <= presc_reg + 1'b1;
        end

        if (terminal) begin
          count_reg  <= '0;
          tick_reg   <= 1'b1;
          toggle_reg <= ~toggle_reg;
          if (oneshot_reg) begin
            // In one-shot mode the terminal tick, done and busy falling all
            // appear in the same cycle. The counters then freeze in DONE.
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end else if (enable) begin
          count_reg <= count_reg + 1'b1;
        end
      end
    end
  end

  assign bus.count      = count_reg;
  assign bus.tick       = tick_reg;
  assign bus.toggle_out = toggle_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;

endmodule

// File: tb/tb_prescaled_tick_timer.sv
// tb_prescaled_tick_timer
//   Directed bench for prescaled_tick_timer. A reference model advances once
//   per rising edge. It derives count and tick arithmetically from the number
//   of edges elapsed since the last accepted start: enables = k/(P+1),
//   count = enables mod (N+1), and a tick occurs when k is a multiple of
//   (P+1)*(N+1). A compare process checks every DUT output against the model
//   on each falling edge. The directed sequences also check literal,
//   hand-computed values.
module tb_prescaled_tick_timer;
  localparam int PW = 8;
  localparam int CW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prescaled_tick_timer_if #(.PRESCALE_W(PW), .CNT_W(CW)) bus ();

  prescaled_tick_timer #(.PRESCALE_W(PW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    longint k;
    int     p;
    int     n;
    bit     os;
    bit     run;
    int     cnt;
    bit     tick;
    bit     tog;
    bit     busy;
    bit     done;
  } model_t;

  model_t m;

  function automatic model_t step(input model_t s, input logic rn, input logic st,
                                  input logic sp, input logic os,
                                  input logic [PW-1:0] p, input logic [CW-1:0] n);
    model_t r;
    r = s;
    if (!rn) begin
      r = '0;
    end else if ((st && sp) || (sp && s.run)) begin
      r.run  = 1'b0;
      r.busy = 1'b0;
      r.tick = 1'b0;
    end else if (st) begin
      r.p    = int'(p);
      r.n    = int'(n);
      r.os   = os;
      r.k    = 0;
      r.run  = 1'b1;
      r.cnt  = 0;
      r.done = 1'b0;
      r.tick = 1'b0;
      r.busy = 1'b1;
    end else if (s.run) begin
      r.k    = s.k + 1;
      r.cnt  = int'((r.k / longint'(r.p + 1)) % longint'(r.n + 1));
      r.tick = ((r.k % (longint'(r.p + 1) * longint'(r.n + 1))) == 0);
      if (r.tick) begin
        r.tog = !s.tog;
        if (r.os) begin
          r.run  = 1'b0;
          r.busy = 1'b0;
          r.done = 1'b1;
        end
      end
    end else begin
      r.tick = 1'b0;
    end
    return r;
  endfunction

  always @(posedge clk)
    m <= step(m, rst_n, bus.start, bus.stop, bus.oneshot, bus.prescale, bus.period);

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_count",  bus.count,      m.cnt);
      chk("cyc_tick",   bus.tick,       m.tick);
      chk("cyc_toggle", bus.toggle_out, m.tog);
      chk("cyc_busy",   bus.busy,       m.busy);
      chk("cyc_done",   bus.done,       m.done);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Drives one start pulse. The task returns at the falling edge just after
  // the start edge (t = 0).
  task automatic start_timer(input int p, input int n, input bit os);
    bus.prescale = PW'(p);
    bus.period   = CW'(n);
    bus.oneshot  = os;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    $display("start P=%0d N=%0d oneshot=%0d", p, n, os);
  endtask

  task automatic stop_timer();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  // Returns the number of cycles until tick is seen, or -1 if no tick
  // arrives within max cycles.
  task automatic wait_tick(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt_ticks;
    int exp_cnt[7];
    exp_cnt = '{0, 0, 1, 1, 2, 2, 0};

    bus.start = 1'b0; bus.stop = 1'b0; bus.oneshot = 1'b0;
    bus.prescale = '0; bus.period = '0;

    // Reset: hold start high while in reset. The reset must win.
    rst_n = 1'b0;
    bus.start = 1'b1; bus.prescale = 8'd5; bus.period = 16'd5;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_count", bus.count, 0);
    chk("rst_tick", bus.tick, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_toggle", bus.toggle_out, 0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    $display("reset checked");

    // Periodic mode with P=1, N=2. The first tick comes 6 cycles after start.
    start_timer(1, 2, 0);
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) @(negedge clk);
      chk("per_count_seq", bus.count, exp_cnt[i]);
      chk("per_tick_at", bus.tick, (i == 6));
    end
    chk("per_tog1", bus.toggle_out, 1);
    chk("per_busy", bus.busy, 1);
    wait_tick(20, n);
    chk("per_gap", n, 6);
    chk("per_tog2", bus.toggle_out, 0);
    $display("periodic: second tick gap=%0d", n);

    // One-shot mode with P=0, N=4.
    start_timer(0, 4, 1);
    wait_tick(20, n);
    chk("os_first", n, 5);
    chk("os_done", bus.done, 1);
    chk("os_busy", bus.busy, 0);
    cnt_ticks = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.tick === 1'b1) cnt_ticks++;
    end
    chk("os_no_more", cnt_ticks, 0);
    chk("os_done_hold", bus.done, 1);
    stop_timer();
    chk("os_done_stop", bus.done, 1);
    start_timer(0, 4, 1);
    chk("os_restart_done", bus.done, 0);
    chk("os_restart_busy", bus.busy, 1);
    stop_timer();
    $display("oneshot: tick after %0d cycles", 5);

    // Stop and restart. Run with P=3, N=9 and stop on the 17th edge.
    start_timer(3, 9, 0);
    repeat (16) @(negedge clk);
    chk("ss_count16", bus.count, 4);
    stop_timer();
    chk("ss_busy", bus.busy, 0);
    chk("ss_frozen", bus.count, 4);
    cnt_ticks = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.tick === 1'b1) cnt_ticks++;
    end
    chk("ss_no_tick", cnt_ticks, 0);
    chk("ss_frozen2", bus.count, 4);
    start_timer(3, 1, 0);
    wait_tick(20, n);
    chk("ss_restart", n, 8);
    bus.period = 16'd5;
    wait_tick(20, n);
    chk("ss_midrun_n", n, 8);
    start_timer(3, 5, 0);
    wait_tick(40, n);
    chk("ss_new_n", n, 24);
    $display("stop/restart: new period gap=%0d", n);

    // Simultaneous start and stop while running. The timer must stop without
    // relatching or clearing the count.
    repeat (10) @(negedge clk);
    chk("ss2_count", bus.count, 2);
    bus.prescale = '0; bus.period = '0;
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("both_busy", bus.busy, 0);
    chk("both_count", bus.count, 2);
    repeat (5) @(negedge clk);
    chk("both_count2", bus.count, 2);
    $display("start+stop: count held at %0d", 2);

    // Reset one cycle before an expected tick.
    start_timer(1, 2, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rb_tick", bus.tick, 0);
    chk("rb_count", bus.count, 0);
    chk("rb_busy", bus.busy, 0);
    chk("rb_toggle", bus.toggle_out, 0);
    $display("reset before tick checked");

    // Degenerate case P=0, N=0: tick every cycle.
    start_timer(0, 0, 0);
    chk("deg_t0", bus.tick, 0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("deg_tick", bus.tick, 1);
      chk("deg_tog", bus.toggle_out, i % 2);
    end
    stop_timer();
    chk("deg_stop_tick", bus.tick, 0);
    $display("degenerate: tick every cycle");

    // Maximum prescale P=255, N=0: tick every 256 cycles.
    start_timer(255, 0, 0);
    wait_tick(300, n);
    chk("max_first", n, 256);
    wait_tick(300, n);
    chk("max_gap", n, 256);
    stop_timer();
    $display("max prescale: gap=%0d", n);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prescaled_tick_timer.md
Name: prescaled_tick_timer

Overview:
- Programmable periodic/one-shot timer sitting directly downstream of the free-running clock generator (clk_gen).
- Consumes that clock and replaces the ad-hoc "always #N toggle/increment" delay idiom with a synthesizable prescaler plus period counter.
- Produces a single-cycle tick pulse, a square-wave toggle output, and status flags for downstream counters and toggle blocks.

Parameters:
- PRESCALE_W, 8, width of prescale divider value
- CNT_W, 16, width of period counter and count output

Ports:
- clk  input  1  system clock from clk_gen; all logic on rising edge
- rst_n  input  1  synchronous reset, active-low
- start  input  1  one-cycle request: latch config, clear counters, enter RUN
- stop  input  1  one-cycle request: abort to IDLE
- oneshot  input  1  1 = stop after first tick; 0 = periodic; latched on start
- prescale  input  PRESCALE_W  divider value P; enable every P+1 clocks; latched on start
- period  input  CNT_W  terminal count N; tick every N+1 enables; latched on start
- count  output  CNT_W  current period counter value
- tick  output  1  one-cycle pulse on terminal count
- toggle_out  output  1  flips on every tick (square wave, half-period = one tick interval)
- busy  output  1  high in RUN
- done  output  1  sticky; set when a one-shot completes, cleared by start or reset

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE, prescaler=0, count=0, tick=0, toggle_out=0, busy=0, done=0, latched config=0. Reset overrides start/stop in the same cycle. Reset mid-RUN aborts immediately; no tick is emitted.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start -> RUN.
  - RUN + stop -> IDLE.
  - RUN + terminal tick with oneshot latched -> DONE.
  - RUN + start (no stop) -> restart in RUN.
- Simultaneous start and stop: stop wins; go to IDLE, config not relatched.
- On an accepted start edge:
  - Latch P, N, oneshot; prescaler=0; count=0; done=0.
  - toggle_out is unchanged.
  - busy=1 from the next cycle.
- In RUN, every edge:
  - If prescaler==P: prescaler->0 and enable=1; else prescaler+1 and enable=0.
  - On enable with count==N: count->0, tick=1 next cycle, toggle_out flips.
  - On enable with count!=N: count+1.
- tick is registered and high for exactly one cycle.
- Tick spacing is (P+1)*(N+1) clocks.
  - First tick is high in the cycle beginning (P+1)*(N+1) edges after the start edge.
  - Degenerate P=0 and N=0 gives tick continuously high (every cycle) in periodic mode.
- Widths: prescaler is PRESCALE_W bits, count is CNT_W bits. The comparison-based wrap means no overflow is possible; the maximum interval is 2^PRESCALE_W * 2^CNT_W.
- One-shot: on the terminal tick, tick=1 and done=1 in the same cycle, busy=0, state=DONE, count=0, and counters freeze.
- IDLE/DONE: counters hold, tick=0, input changes ignored except start.
- Input changes during RUN: changes to prescale/period/oneshot have no effect until the next start.
- stop in IDLE/DONE: ignored; done is retained.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 -> all outputs 0, state IDLE, no tick.
- Periodic: P=1, N=2, start pulse -> first tick 6 cycles after the start edge, then every 6 cycles. toggle_out flips 0->1->0 on successive ticks; busy=1 and done=0 throughout; count sequence is 0,0,1,1,2,2,0...
- One-shot: P=0, N=4, oneshot=1 -> single tick 5 cycles after start, done=1 and busy=0 in the same cycle, no further ticks over 20 cycles; a new start clears done.
- Stop/restart: periodic P=3, N=9; stop at cycle 17 -> busy=0, count frozen, no tick. Start at cycle 30 with N=1 -> tick 8 cycles later. A start with N changed mid-run only takes effect after the restart.
- Simultaneous start+stop while in RUN -> IDLE, config not relatched. Synchronous reset asserted one cycle before an expected tick -> no tick, outputs 0 on the next cycle.
- Degenerate: P=0, N=0 periodic -> tick high every cycle after start, toggle_out alternates every cycle. Max P=255 with N=0 -> tick every 256 cycles.
